scroll_trace_render: RTL
========================

# scroll_trace_render

Pixel-stream renderer that reads the 1-bit sample history held in the scrolling waveform buffer and draws it as a logic-analyzer trace on the VGA display. It sits between the VGA sync generator (pixel x/y, video_on, hsync/vsync) and the RGB output stage. It drives the buffer's read address from the current pixel column, consumes the buffer's 1-cycle-latency read data, and emits delay-matched RGB and sync.

## Interface
Parameters:
- ADDR_WIDTH, 9: buffer read-address width.
- MAX, 480: number of trace columns; columns x ≥ MAX are background.
- HI_Y, 100: row drawn for a sample of 1.
- LO_Y, 200: row drawn for a sample of 0; must be > HI_Y.
- GRID_LOG2, 5: grid pitch is 2^GRID_LOG2 pixels in x and y.
- TRACE_RGB, 12'h0F0; GRID_RGB, 12'h333; BG_RGB, 12'h000.

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  synchronous, active-high.
- x  in  10  current pixel column from the sync generator.
- y  in  10  current pixel row.
- video_on  in  1  visible-area flag.
- hsync_in, vsync_in  in  1 each  raw sync from the generator.
- addr_r  out  ADDR_WIDTH  buffer read address.
- sample  in  1  buffer read data, valid the cycle after addr_r.
- rgb  out  12  pixel colour.
- hsync, vsync  out  1 each  sync delayed to match rgb.

## Operation
- addr_r = x[ADDR_WIDTH-1:0] when x < MAX, else 0. Combinational, no register.
- Stage 1 registers x1, y1, von1, hs1, vs1.
- prev register holds the sample of the previous column on the same line:
  - when von1 and x1 < MAX, prev ← sample at the end of each cycle;
  - when x1 == 0, the edge test uses prev := sample (no edge drawn in column 0).
- Stage 2 computes rgb from x1, y1, von1, s = sample, p = prev. Rules in priority order:
  1. !von1 → 12'h000.
  2. x1 ≥ MAX → BG_RGB.
  3. Level: (s && y1 == HI_Y) or (!s && y1 == LO_Y) → TRACE_RGB.
  4. Edge: s != p and x1 != 0 and HI_Y ≤ y1 ≤ LO_Y → TRACE_RGB.
  5. Grid: x1[GRID_LOG2-1:0] == 0 or y1[GRID_LOG2-1:0] == 0 → GRID_RGB.
  6. Otherwise BG_RGB.
- hsync and vsync are hs1/vs1 registered once more.
- Rendering is stateless across lines and frames except for prev. Buffer scrolling mid-frame is allowed; tearing is accepted.

## Timing
- Latency from x/y/video_on/sync input to rgb/hsync/vsync output: exactly 2 cycles.
- sample is consumed in the cycle after addr_r, aligned with stage 1.
- Reset (synchronous) clears stage 1, stage 2 and prev:
  - rgb = 0, hsync = 0, vsync = 0, prev = 0.
  - addr_r still follows x.
- Reset mid-line: outputs are 0 for the reset cycle and the following 2 cycles, then normal operation resumes. In the first post-reset column (when x1 ≠ 0), prev = 0.
- Column boundaries:
  - x1 == MAX-1 is the last trace column.
  - x1 == MAX is background; prev is not updated there.
- HI_Y == y1 with an edge present: the level rule and the edge rule both give TRACE_RGB (no conflict).

## Structure
- Shared package (e.g. video_pkg) holds the rgb_t 12-bit typedef, the colour constants, and the HI_Y/LO_Y defaults.
- One sub-module, trace_pixel_logic: combinational priority rules 1–6 taking x1, y1, von1, s, p. The top level holds addr_r logic, pipeline registers and prev.

## Test plan
- Reset with x = 5, video_on = 1: rgb, hsync and vsync stay 0 during reset and 2 cycles after; addr_r = 5 throughout.
- Constant sample = 1, y = 100, x sweeps 0..639 → rgb = 12'h0F0 for x = 0..479 two cycles later, BG for 480..639. The same sweep at y = 200 → no trace, grid only at x multiples of 32.
- Sample toggles 0→1 at column 10, y = 150 → TRACE_RGB at x = 10 only. Column 0 with prev from the previous line = 0 and s = 1 → no edge.
- y = 64, sample = 0 → GRID_RGB across the line; x = 64, y = 65 → GRID_RGB.
- hsync_in pulse at cycle n → hsync pulse at cycle n+2 with identical width; video_on = 0 → rgb = 0 regardless of sample.
- Reset asserted at x = 200 for 1 cycle with sample = 1 from x = 203 on: no edge drawn at 203 spuriously only if prev reloads at 202. Verify rgb at x = 203, y = 150 = TRACE_RGB (prev = 0 post-reset) and level rows are correct thereafter.

Source files
------------

// File: rtl/scroll_trace_render_pkg.sv
// Shared pixel types, colour constants and trace row defaults for the waveform renderer.
// Pure definitions; no logic, no latency, no flow control.
package scroll_trace_render_pkg;

  typedef logic [11:0] rgb_t;

  localparam rgb_t BLANK_RGB     = 12'h000;
  localparam rgb_t TRACE_RGB_DEF = 12'h0F0;
  localparam rgb_t GRID_RGB_DEF  = 12'h333;
  localparam rgb_t BG_RGB_DEF    = 12'h000;

  localparam int HI_Y_DEF = 100;
  localparam int LO_Y_DEF = 200;

endpackage

// File: rtl/trace_pixel_logic.sv
// Colour decision for one pixel of the trace, grid and background layers.
// Purely combinational, zero latency; no backpressure (free-running pixel stream).
module trace_pixel_logic
  import scroll_trace_render_pkg::*;
#(
  parameter int   MAX       = 480,
  parameter int   HI_Y      = HI_Y_DEF,
  parameter int   LO_Y      = LO_Y_DEF,
  parameter int   GRID_LOG2 = 5,
  parameter rgb_t TRACE_RGB = TRACE_RGB_DEF,
  parameter rgb_t GRID_RGB  = GRID_RGB_DEF,
  parameter rgb_t BG_RGB    = BG_RGB_DEF
) (
  input  logic [9:0]  x1,
  input  logic [9:0]  y1,
  input  logic        von1,
  input  logic        s,
  input  logic        p,
  output logic [11:0] rgb
);

  localparam logic [9:0] MAX_X = 10'(MAX);
  localparam logic [9:0] HI_R  = 10'(HI_Y);
  localparam logic [9:0] LO_R  = 10'(LO_Y);

  logic level_hit;
  logic edge_hit;
  logic grid_hit;

  assign level_hit = (s && (y1 == HI_R)) || (!s && (y1 == LO_R));
  // Vertical stroke joins the two level rows wherever the sample changed.
  assign edge_hit  = (s != p) && (x1 != '0) && (y1 >= HI_R) && (y1 <= LO_R);
  assign grid_hit  = (x1[GRID_LOG2-1:0] == '0) || (y1[GRID_LOG2-1:0] == '0);

  always_comb begin
    rgb = BG_RGB;
    if (!von1)              rgb = BLANK_RGB;
    else if (x1 >= MAX_X)   rgb = BG_RGB;
    else if (level_hit)     rgb = TRACE_RGB;
    else if (edge_hit)      rgb = TRACE_RGB;
    else if (grid_hit)      rgb = GRID_RGB;
    else                    rgb = BG_RGB;
  end

endmodule

// File: rtl/scroll_trace_render.sv
// Draws the scrolling 1-bit sample buffer as a logic-analyzer trace; rgb/hsync/vsync lag inputs by 2 cycles.
// No backpressure: one pixel per clock, buffer read data expected exactly 1 cycle after addr_r.
module scroll_trace_render
  import scroll_trace_render_pkg::*;
#(
  parameter int   ADDR_WIDTH = 9,
  parameter int   MAX        = 480,
  parameter int   HI_Y       = HI_Y_DEF,
  parameter int   LO_Y       = LO_Y_DEF,
  parameter int   GRID_LOG2  = 5,
  parameter rgb_t TRACE_RGB  = TRACE_RGB_DEF,
  parameter rgb_t GRID_RGB   = GRID_RGB_DEF,
  parameter rgb_t BG_RGB     = BG_RGB_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic                  video_on,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  output logic [ADDR_WIDTH-1:0] addr_r,
  input  logic                  sample,
  output logic [11:0]           rgb,
  output logic                  hsync,
  output logic                  vsync
);

  localparam logic [9:0] MAX_X = 10'(MAX);

  logic [9:0] x1;
  logic [9:0] y1;
  logic       von1;
  logic       hs1;
  logic       vs1;
  logic       prev;
  logic       p_eff;
  rgb_t       pix_rgb;

  assign addr_r = (x < MAX_X) ? x[ADDR_WIDTH-1:0] : '0;

  // Column 0 never compares against the previous line's last sample.
  assign p_eff = (x1 == '0) ? sample : prev;

  trace_pixel_logic #(
    .MAX       (MAX),
    .HI_Y      (HI_Y),
    .LO_Y      (LO_Y),
    .GRID_LOG2 (GRID_LOG2),
    .TRACE_RGB (TRACE_RGB),
    .GRID_RGB  (GRID_RGB),
    .BG_RGB    (BG_RGB)
  ) u_pixel (
    .x1   (x1),
    .y1   (y1),
    .von1 (von1),
    .s    (sample),
    .p    (p_eff),
    .rgb  (pix_rgb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      x1    <= '0;
      y1    <= '0;
      von1  <= 1'b0;
      hs1   <= 1'b0;
      vs1   <= 1'b0;
      prev  <= 1'b0;
      rgb   <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else begin
      x1    <= x;
      y1    <= y;
      von1  <= video_on;
      hs1   <= hsync_in;
      vs1   <= vsync_in;
      rgb   <= pix_rgb;
      hsync <= hs1;
      vsync <= vs1;
      if (von1 && (x1 < MAX_X)) prev <= sample;
    end
  end

endmodule
